// File: rtl/sbox_out_map_stage.sv
// Output linear map + affine stage of the S-box, with a two-register valid/ready pipeline.
// Optional macro SBOX_OUT_PARITY_EN registers even parity of out_data alongside it.
module sbox_out_map_stage #(
    parameter logic [63:0] MAT_FWD  = 64'h8040201008040201,
    parameter logic [63:0] MAT_INV  = 64'h8040201008040201,
    parameter logic [7:0]  AFFINE_C = 8'h63
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_z,
    input  logic [3:0] in_w,
    input  logic       in_enc,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_par
);

    logic       s1_v;
    logic       s2_v;
    logic [7:0] v1;
    logic       enc1;
    logic [7:0] data2;
    logic [7:0] mapped;
    logic [63:0] mat;
    logic       s2_free;
    logic       s1_adv;
    logic       accept;

    assign s2_free  = !s2_v | out_ready;
    assign s1_adv   = s1_v & s2_free & !flush;
    assign in_ready = !s1_v | s2_free;
    assign accept   = in_valid & in_ready & !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v <= 1'b0;
            v1   <= 8'h00;
            enc1 <= 1'b0;
        end else begin
            if (flush) begin
                s1_v <= 1'b0;
            end else if (accept) begin
                s1_v <= 1'b1;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
            if (accept) begin
                v1   <= {in_w, in_z};
                enc1 <= in_enc;
            end
        end
    end

    // Row i of the selected matrix produces bit i; the constant only applies going forward.
    always_comb begin
        mapped = 8'h00;
        mat    = enc1 ? MAT_FWD : MAT_INV;
        for (int i = 0; i < 8; i++) begin
            mapped[i] = ^(mat[8*i +: 8] & v1);
        end
        if (enc1) begin
            mapped = mapped ^ AFFINE_C;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_v  <= 1'b0;
            data2 <= 8'h00;
        end else begin
            if (flush) begin
                s2_v <= 1'b0;
            end else if (s1_adv) begin
                s2_v <= 1'b1;
            end else if (s2_v && out_ready) begin
                s2_v <= 1'b0;
            end
            if (s1_adv) begin
                data2 <= mapped;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_data  = data2;

`ifdef SBOX_OUT_PARITY_EN
    logic par2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par2 <= 1'b0;
        end else if (s1_adv) begin
            par2 <= ^mapped;
        end
    end

    assign out_par = par2;
`else
    assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_sbox_out_map_stage.sv
// Directed self-checking bench for sbox_out_map_stage (identity matrices, affine 0x63).
// Covers forward/inverse map, back-to-back modes, backpressure, streaming, flush and async reset.
module tb_sbox_out_map_stage;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_z;
    logic [3:0] in_w;
    logic       in_enc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_par;

    int tests_run;
    int tests_failed;

    sbox_out_map_stage dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_z     (in_z),
        .in_w     (in_w),
        .in_enc   (in_enc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_par  (out_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic enc, input logic [3:0] w, input logic [3:0] z);
        in_valid = valid;
        in_enc   = enc;
        in_w     = w;
        in_z     = z;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference with identity matrices: forward adds 0x63, inverse passes through.
    function automatic logic [7:0] model_map(input logic [7:0] v, input logic enc);
        return enc ? (v ^ 8'h63) : v;
    endfunction

    function automatic logic model_par(input logic [7:0] d);
`ifdef SBOX_OUT_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    logic [7:0] exp_q[$];
    int sent;
    int received;
    int cycles;
    logic do_acc;
    logic do_con;
    logic [7:0] exp_b;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);

        #12;
        checkOutput("rst_out_valid", {7'd0, out_valid}, 8'h00);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_out_par", {7'd0, out_par}, 8'h00);
        checkOutput("rst_in_ready", {7'd0, in_ready}, 8'h01);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Forward map
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'hA, 4'h5);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("fwd_not_early", {7'd0, out_valid}, 8'h00);
        tick();
        checkOutput("fwd_valid", {7'd0, out_valid}, 8'h01);
        checkOutput("fwd_data", out_data, 8'hC6);
        checkOutput("fwd_par", {7'd0, out_par}, {7'd0, model_par(8'hC6)});
        tick();
        checkOutput("fwd_drained", {7'd0, out_valid}, 8'h00);

        // Inverse map
        applyStimulus(1'b1, 1'b0, 4'hA, 4'h5);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        checkOutput("inv_valid", {7'd0, out_valid}, 8'h01);
        checkOutput("inv_data", out_data, 8'hA5);
        checkOutput("inv_par", {7'd0, out_par}, {7'd0, model_par(8'hA5)});
        tick();

        // Back-to-back mixed modes, no bubbles
        applyStimulus(1'b1, 1'b1, 4'hA, 4'h5);
        tick();
        applyStimulus(1'b1, 1'b0, 4'hA, 4'h5);
        tick();
        checkOutput("b2b_v0", {7'd0, out_valid}, 8'h01);
        checkOutput("b2b_d0", out_data, 8'hC6);
        applyStimulus(1'b1, 1'b1, 4'hA, 4'h5);
        tick();
        checkOutput("b2b_v1", {7'd0, out_valid}, 8'h01);
        checkOutput("b2b_d1", out_data, 8'hA5);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        checkOutput("b2b_v2", {7'd0, out_valid}, 8'h01);
        checkOutput("b2b_d2", out_data, 8'hC6);
        tick();
        checkOutput("b2b_drained", {7'd0, out_valid}, 8'h00);

        // Backpressure: two accepted, third stalls until the consumer returns
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'hA, 4'h5);
        tick();
        applyStimulus(1'b1, 1'b0, 4'h3, 4'hC);
        #1;
        checkOutput("bp_ready_second", {7'd0, in_ready}, 8'h01);
        tick();
        applyStimulus(1'b1, 1'b1, 4'h0, 4'h0);
        #1;
        checkOutput("bp_ready_full", {7'd0, in_ready}, 8'h00);
        checkOutput("bp_hold_data0", out_data, 8'hC6);
        tick();
        checkOutput("bp_still_full", {7'd0, in_ready}, 8'h00);
        checkOutput("bp_hold_valid", {7'd0, out_valid}, 8'h01);
        checkOutput("bp_hold_data1", out_data, 8'hC6);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_release", {7'd0, in_ready}, 8'h01);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("bp_out1", out_data, 8'h3C);
        tick();
        checkOutput("bp_out2_valid", {7'd0, out_valid}, 8'h01);
        checkOutput("bp_out2", out_data, 8'h63);
        tick();
        checkOutput("bp_drained", {7'd0, out_valid}, 8'h00);

        // Streaming with random consumer stalls against a scoreboard
        sent = 0;
        received = 0;
        cycles = 0;
        while (received < 256 && cycles < 4000) begin
            if (sent < 256) begin
                applyStimulus(1'b1, sent[1], sent[7:4], sent[3:0]);
            end else begin
                applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            do_acc = in_valid & in_ready;
            do_con = out_valid & out_ready;
            if (do_con) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                checkOutput("stream_data", out_data, exp_b);
                received++;
            end
            if (do_acc) begin
                exp_q.push_back(model_map(sent[7:0], sent[1]));
                sent++;
            end
            tick();
            cycles++;
        end
        checkOutput("stream_timeout", {7'd0, (cycles >= 4000)}, 8'h00);
        checkOutput("stream_count", {7'd0, (sent == received)}, 8'h01);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        out_ready = 1'b1;
        tick();
        tick();

        // Flush drops both bytes in flight and the beat presented alongside it
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'h1, 4'h1);
        tick();
        applyStimulus(1'b1, 1'b0, 4'h2, 4'h2);
        tick();
        applyStimulus(1'b1, 1'b1, 4'h7, 4'h7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("flush_valid", {7'd0, out_valid}, 8'h00);
        out_ready = 1'b1;
        tick();
        checkOutput("flush_nothing", {7'd0, out_valid}, 8'h00);
        applyStimulus(1'b1, 1'b1, 4'h4, 4'h4);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        checkOutput("post_flush_valid", {7'd0, out_valid}, 8'h01);
        checkOutput("post_flush_data", out_data, 8'h27);
        tick();
        checkOutput("post_flush_drained", {7'd0, out_valid}, 8'h00);

        // Asynchronous reset between edges with the pipeline full
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'hA, 4'h5);
        tick();
        applyStimulus(1'b1, 1'b0, 4'h3, 4'hC);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        checkOutput("prerst_valid", {7'd0, out_valid}, 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_valid", {7'd0, out_valid}, 8'h00);
        checkOutput("arst_data", out_data, 8'h00);
        checkOutput("arst_in_ready", {7'd0, in_ready}, 8'h01);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checkOutput("postrst_valid", {7'd0, out_valid}, 8'h00);
        checkOutput("postrst_in_ready", {7'd0, in_ready}, 8'h01);
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'hF, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        checkOutput("postrst_out_valid", {7'd0, out_valid}, 8'h01);
        checkOutput("postrst_out_data", out_data, 8'hF0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sbox_out_map_stage.md
Name: sbox_out_map_stage

Overview:
- Pipelined stage directly downstream of the combined S-box output multiplier.
- Takes the two 4-bit normal-basis products Z and W, with an encrypt/decrypt mode flag, and applies the output linear transform (8x8 GF(2) matrix) to produce the final S-box byte.
- Applies the affine constant in forward (encrypt) mode.
- Has a 2-register valid/ready pipeline so the S-box datapath can be cut for timing and can absorb downstream backpressure.

Parameters:
- MAT_FWD, 64'h8040201008040201, forward-mode output matrix. Row i is MAT_FWD[8*i+7:8*i]; the default is identity.
- MAT_INV, 64'h8040201008040201, inverse-mode output matrix, same row layout.
- AFFINE_C, 8'h63, constant XORed into the result in forward mode only.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of both pipeline valids
- in_valid  in  1  Z/W/in_enc valid
- in_ready  out  1  stage can accept this cycle
- in_z  in  4  Z product from output multiplier
- in_w  in  4  W product from output multiplier
- in_enc  in  1  1 = forward S-box, 0 = inverse S-box
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts this cycle
- out_data  out  8  mapped S-box byte
- out_par  out  1  even parity of out_data (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain, clk. reset_n is asynchronous and active-low; when low, all state clears immediately, independent of clk.
- Reset values: s1_v=0, s2_v=0, out_valid=0, out_data=8'h00, out_par=0, internal data regs=0. in_ready is combinational and equals 1 while in reset-derived empty state.
- Reset mid-operation: all in-flight data is discarded with no partial output. After release, the first accept behaves as from empty.
- Stage 1 (capture) registers v={in_w,in_z} (v[7:4]=W, v[3:0]=Z) and in_enc.
- Stage 2 (map) registers:
  - out_data[i] = ^(row_i & v1), with row from MAT_FWD if enc1=1, else MAT_INV.
  - Then XOR AFFINE_C when enc1=1.
  - Inverse mode applies no constant, because the inverse affine is handled upstream.
- Handshake and advance logic:
  - s2_free = !s2_v | out_ready.
  - s1_adv = s1_v & s2_free.
  - in_ready = !s1_v | s2_free. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Transfer rules:
  - Input accepted on an edge where in_valid & in_ready; output consumed on an edge where out_valid & out_ready.
  - Stage 1 loads on accept. Otherwise s1_v clears on s1_adv, else it holds.
  - Stage 2 loads on s1_adv. Otherwise s2_v clears when consumed, else it holds.
- Latency and throughput: data accepted at edge k appears on out_valid/out_data after edge k+1 (2-cycle latency). Full throughput is 1 byte/cycle with out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_par are held stable. Stage 1 may still fill, making 2 bytes in flight. When both are full, in_ready=0.
- Simultaneous events:
  - Accept and advance on the same edge: stage 1 takes new data and stage 2 takes old stage-1 data; no bubble.
  - Consume with s1_v=0: s2_v goes to 0.
- Flush: on an edge with flush=1, s1_v and s2_v clear and no input is accepted that cycle, regardless of in_valid. in_ready may read 1 during flush, but the beat is dropped; upstream must not present data under flush. Data registers are not cleared.
- Mode: in_enc travels with its data, so mixed enc/dec streams are allowed back-to-back.
- No X propagation: data registers load only when their valid is set.

Optional Feature:
- Macro: SBOX_OUT_PARITY_EN.
- Defined: stage 2 also registers out_par = ^out_data_next, updated on the same edges as out_data. It resets to 0 and is held under stall.
- Undefined: out_par is tied to constant 0 and no parity logic is synthesized. The port list is unchanged.

Test Plan:
- Forward map: reset, in_enc=1, in_w=4'hA, in_z=4'h5, out_ready=1 -> out_valid 2 cycles later, out_data=8'hC6 (0xA5^0x63), out_par=0 with macro.
- Inverse map: same input with in_enc=0 -> out_data=8'hA5, out_par=0. Then back-to-back enc=1/enc=0/enc=1 inputs -> outputs C6,A5,C6 on consecutive cycles, no bubbles.
- Backpressure: out_ready=0, drive 3 valid inputs -> first 2 accepted, in_ready=0 on the third. out_data held at the first result. Raise out_ready -> 3 results in order, no loss or duplication.
- Streaming: 256 consecutive bytes (W,Z = counter) with out_ready random 50% -> every output equals the model map in order. Count in equals count out.
- Flush: 2 bytes in flight, assert flush 1 cycle -> out_valid=0 next cycle, those bytes never appear. Next input emerges normally 2 cycles after accept.
- Reset mid-operation: pipeline full, drop reset_n asynchronously between edges -> out_valid=0 and out_data=00 immediately. After release, in_ready=1 and normal operation resumes.
